// File: rtl/core_array_rbus_pkg.sv
// rtl/core_array_rbus_pkg.sv - shared types and arbitration encoding for the row read-bus collector
package core_array_rbus_pkg;

  localparam int RBUS_DATA_W     = 32;
  localparam int RBUS_V_NUM      = 8;
  localparam int RBUS_SLOT_DEPTH = 4;

  typedef logic [RBUS_DATA_W-1:0]               rbus_word_t;
  typedef logic [$clog2(RBUS_V_NUM)-1:0]        rbus_col_t;
  typedef logic [$clog2(RBUS_SLOT_DEPTH+1)-1:0] rbus_count_t;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Round-robin successor of a column, wrapping at v_num.
  function automatic int next_col(input int col, input int v_num);
    return (col + 1 == v_num) ? 0 : col + 1;
  endfunction

endpackage

// File: rtl/rbus_slot_fifo.sv
// rtl/rbus_slot_fifo.sv - per-core result slot FIFO; a full slot still accepts a push when popped in the same cycle
module rbus_slot_fifo
  import core_array_rbus_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int SLOT_DEPTH = 4,
  localparam int AW         = $clog2(SLOT_DEPTH),
  localparam int CW         = $clog2(SLOT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [SLOT_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(SLOT_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because SLOT_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/core_array_rbus_collector.sv
// rtl/core_array_rbus_collector.sv - buffered per-row collection of core read results with RR/fixed arbitration
module core_array_rbus_collector
  import core_array_rbus_pkg::*;
#(
  parameter int H_NUM      = 8,
  parameter int V_NUM      = 8,
  parameter int DATA_W     = 32,
  parameter int SLOT_DEPTH = 4,
  parameter int COL_W      = $clog2(V_NUM)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_rr_en,
  input  logic [H_NUM-1:0][V_NUM-1:0]           in_valid,
  input  logic [H_NUM-1:0][V_NUM-1:0][DATA_W-1:0] in_data,
  output logic [H_NUM-1:0][V_NUM-1:0]           slot_almost_full,
  output logic [H_NUM-1:0][V_NUM-1:0]           slot_overflow,
  input  logic                                  ovf_clear,
  output logic [H_NUM-1:0]                      out_valid,
  input  logic [H_NUM-1:0]                      out_ready,
  output logic [H_NUM-1:0][DATA_W-1:0]          out_data,
  output logic [H_NUM-1:0][COL_W-1:0]           out_col
);

  localparam int CW = $clog2(SLOT_DEPTH + 1);

  arb_mode_e mode;
  assign mode = arb_mode_e'(cfg_rr_en);

  for (genvar i = 0; i < H_NUM; i++) begin : g_row
    logic [V_NUM-1:0]  nonempty;
    logic [V_NUM-1:0]  pop;
    logic [DATA_W-1:0] head [V_NUM];
    logic [COL_W-1:0]  ptr;
    logic [COL_W-1:0]  start;
    logic [COL_W-1:0]  gcol;
    logic              found;
    logic              load;
    logic              row_valid;
    logic [DATA_W-1:0] row_data;
    logic [COL_W-1:0]  row_col;

    for (genvar j = 0; j < V_NUM; j++) begin : g_slot
      logic [CW-1:0] count;
      logic          full;
      logic          empty;
      logic          ovf;

      rbus_slot_fifo #(
        .DATA_W     (DATA_W),
        .SLOT_DEPTH (SLOT_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid[i][j]),
        .push_data (in_data[i][j]),
        .pop       (pop[j]),
        .head      (head[j]),
        .count     (count),
        .full      (full),
        .empty     (empty)
      );

      assign nonempty[j]            = ~empty;
      assign pop[j]                 = load & found & (gcol == COL_W'(j));
      // count is a register, so this flag reflects the post-edge occupancy.
      assign slot_almost_full[i][j] = (count >= CW'(SLOT_DEPTH - 1));
      assign slot_overflow[i][j]    = ovf;

      always_ff @(posedge clk) begin
        if (rst)                                 ovf <= 1'b0;
        else if (in_valid[i][j] & full & ~pop[j]) ovf <= 1'b1;
        else if (ovf_clear)                      ovf <= 1'b0;
      end
    end

    assign start = (mode == ARB_RR) ? ptr : '0;
    assign load  = ~row_valid | out_ready[i];

    always_comb begin
      found = 1'b0;
      gcol  = '0;
      for (int k = 0; k < V_NUM; k++) begin
        if (!found && nonempty[(int'(start) + k) % V_NUM]) begin
          found = 1'b1;
          gcol  = COL_W'((int'(start) + k) % V_NUM);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        row_valid <= 1'b0;
        row_data  <= '0;
        row_col   <= '0;
        ptr       <= '0;
      end else if (load) begin
        if (found) begin
          row_valid <= 1'b1;
          row_data  <= head[gcol];
          row_col   <= gcol;
          if (mode == ARB_RR) ptr <= COL_W'(next_col(int'(gcol), V_NUM));
        end else begin
          row_valid <= 1'b0;
        end
      end
    end

    assign out_valid[i] = row_valid;
    assign out_data[i]  = row_data;
    assign out_col[i]   = row_col;
  end

endmodule

// File: tb/tb_core_array_rbus_collector.sv
// tb/tb_core_array_rbus_collector.sv - directed self-checking bench for the row read-bus collector
module tb_core_array_rbus_collector;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_rr_en;
  logic [1:0][3:0]       in_valid;
  logic [1:0][3:0][31:0] in_data;
  logic [1:0][3:0]       slot_almost_full;
  logic [1:0][3:0]       slot_overflow;
  logic                  ovf_clear;
  logic [1:0]            out_valid;
  logic [1:0]            out_ready;
  logic [1:0][31:0]      out_data;
  logic [1:0][1:0]       out_col;

  int checks = 0;
  int failures = 0;

  core_array_rbus_collector #(
    .H_NUM(2), .V_NUM(4), .DATA_W(32), .SLOT_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .cfg_rr_en(cfg_rr_en),
    .in_valid(in_valid), .in_data(in_data),
    .slot_almost_full(slot_almost_full), .slot_overflow(slot_overflow),
    .ovf_clear(ovf_clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_col(out_col)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = '0; ovf_clear = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    cfg_rr_en = 1'b1; out_ready = 2'b11; in_data = '0;
    do_reset;
    checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (out_col !== '0) begin failures++; $display("FAIL reset_col got=%h exp=0", out_col); end
    checks++; if (slot_almost_full !== '0) begin failures++; $display("FAIL reset_afull got=%h exp=0", slot_almost_full); end
    checks++; if (slot_overflow !== '0) begin failures++; $display("FAIL reset_ovf got=%h exp=0", slot_overflow); end
  endtask

  task automatic test_single;
    in_valid[0][2] = 1'b1; in_data[0][2] = 32'hA5;
    tick;
    in_valid = '0;
    checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL single_latency got=%b exp=00", out_valid); end
    tick;
    checks++; if (out_valid !== 2'b01) begin failures++; $display("FAIL single_valid got=%b exp=01", out_valid); end
    checks++; if (out_data[0] !== 32'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", out_data[0]); end
    checks++; if (out_col[0] !== 2'd2) begin failures++; $display("FAIL single_col got=%0d exp=2", out_col[0]); end
    tick;
    checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL single_drain got=%b exp=00", out_valid); end
  endtask

  task automatic test_round_robin;
    do_reset;
    cfg_rr_en = 1'b1; out_ready = 2'b11;
    in_valid[0] = 4'b1010; in_data[0][1] = 32'h11; in_data[0][3] = 32'h33;
    tick;
    in_valid = '0;
    tick;
    checks++; if (out_valid[0] !== 1'b1 || out_col[0] !== 2'd1 || out_data[0] !== 32'h11) begin failures++; $display("FAIL rr_first got=v%b c%0d d%h exp=v1 c1 d11", out_valid[0], out_col[0], out_data[0]); end
    tick;
    checks++; if (out_valid[0] !== 1'b1 || out_col[0] !== 2'd3 || out_data[0] !== 32'h33) begin failures++; $display("FAIL rr_second got=v%b c%0d d%h exp=v1 c3 d33", out_valid[0], out_col[0], out_data[0]); end
    in_valid[0] = 4'b1111;
    for (int c = 0; c < 4; c++) in_data[0][c] = 32'h40 + c;
    tick;
    in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++; if (out_valid[0] !== 1'b1 || out_col[0] !== 2'(k) || out_data[0] !== 32'h40 + k) begin failures++; $display("FAIL rr_all_%0d got=v%b c%0d d%h exp=v1 c%0d d%h", k, out_valid[0], out_col[0], out_data[0], k, 32'h40 + k); end
    end
    tick;
    checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL rr_idle got=%b exp=0", out_valid[0]); end
  endtask

  task automatic test_fixed_priority;
    do_reset;
    cfg_rr_en = 1'b0; out_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      in_valid[0][0] = 1'b1; in_data[0][0] = 32'h100 + k;
      in_valid[0][1] = (k == 0); in_data[0][1] = 32'h200;
      tick;
      if (k >= 1) begin
        checks++; if (out_valid[0] !== 1'b1 || out_col[0] !== 2'd0 || out_data[0] !== 32'h100 + k - 1) begin failures++; $display("FAIL fixed_col0_%0d got=v%b c%0d d%h exp=v1 c0 d%h", k, out_valid[0], out_col[0], out_data[0], 32'h100 + k - 1); end
      end
    end
    in_valid = '0;
    tick;
    checks++; if (out_col[0] !== 2'd0 || out_data[0] !== 32'h105) begin failures++; $display("FAIL fixed_last0 got=c%0d d%h exp=c0 d105", out_col[0], out_data[0]); end
    tick;
    checks++; if (out_valid[0] !== 1'b1 || out_col[0] !== 2'd1 || out_data[0] !== 32'h200) begin failures++; $display("FAIL fixed_col1 got=v%b c%0d d%h exp=v1 c1 d200", out_valid[0], out_col[0], out_data[0]); end
    tick;
    checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL fixed_idle got=%b exp=0", out_valid[0]); end
  endtask

  task automatic test_overflow;
    do_reset;
    cfg_rr_en = 1'b1; out_ready = 2'b00;
    for (int k = 0; k < 6; k++) begin
      in_valid[0][0] = 1'b1; in_data[0][0] = 32'(k + 1);
      tick;
      if (k >= 1) begin
        checks++; if (out_valid[0] !== 1'b1 || out_data[0] !== 32'h1) begin failures++; $display("FAIL ovf_hold_%0d got=v%b d%h exp=v1 d1", k, out_valid[0], out_data[0]); end
      end
      if (k == 2) begin
        checks++; if (slot_almost_full[0][0] !== 1'b0) begin failures++; $display("FAIL ovf_afull_early got=%b exp=0", slot_almost_full[0][0]); end
      end
      if (k == 3) begin
        checks++; if (slot_almost_full[0][0] !== 1'b1) begin failures++; $display("FAIL ovf_afull_set got=%b exp=1", slot_almost_full[0][0]); end
      end
      if (k == 4) begin
        checks++; if (slot_overflow[0][0] !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", slot_overflow[0][0]); end
      end
      if (k == 5) begin
        checks++; if (slot_overflow !== 8'h01) begin failures++; $display("FAIL ovf_set got=%h exp=01", slot_overflow); end
      end
    end
    in_valid = '0;
    out_ready[0] = 1'b1;
    for (int v = 2; v <= 5; v++) begin
      tick;
      checks++; if (out_valid[0] !== 1'b1 || out_data[0] !== 32'(v)) begin failures++; $display("FAIL ovf_drain_%0d got=v%b d%h exp=v1 d%h", v, out_valid[0], out_data[0], v); end
    end
    tick;
    checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", out_valid[0]); end
    checks++; if (slot_overflow[0][0] !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", slot_overflow[0][0]); end
    ovf_clear = 1'b1;
    tick;
    ovf_clear = 1'b0;
    checks++; if (slot_overflow[0][0] !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", slot_overflow[0][0]); end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h72; exp_seq[1] = 32'h73; exp_seq[2] = 32'h74; exp_seq[3] = 32'h77;
    do_reset;
    cfg_rr_en = 1'b1; out_ready = 2'b00;
    for (int k = 0; k < 5; k++) begin
      in_valid[1][3] = 1'b1; in_data[1][3] = 32'h70 + k;
      tick;
    end
    checks++; if (slot_almost_full[1][3] !== 1'b1 || out_data[1] !== 32'h70) begin failures++; $display("FAIL fpp_full got=af%b d%h exp=af1 d70", slot_almost_full[1][3], out_data[1]); end
    out_ready[1] = 1'b1; in_data[1][3] = 32'h77;
    tick;
    in_valid = '0;
    checks++; if (slot_overflow !== '0) begin failures++; $display("FAIL fpp_no_ovf got=%h exp=0", slot_overflow); end
    checks++; if (out_data[1] !== 32'h71 || out_col[1] !== 2'd3) begin failures++; $display("FAIL fpp_pop got=d%h c%0d exp=d71 c3", out_data[1], out_col[1]); end
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++; if (out_valid[1] !== 1'b1 || out_data[1] !== exp_seq[k]) begin failures++; $display("FAIL fpp_seq_%0d got=v%b d%h exp=v1 d%h", k, out_valid[1], out_data[1], exp_seq[k]); end
    end
    tick;
    checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL fpp_idle got=%b exp=00", out_valid); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    cfg_rr_en = 1'b1; out_ready = 2'b00;
    in_valid[0] = 4'b0101; in_data[0][0] = 32'hD0; in_data[0][2] = 32'hD2;
    in_valid[1][1] = 1'b1; in_data[1][1] = 32'hE1;
    tick;
    in_valid = '0; in_valid[0][0] = 1'b1;
    tick;
    in_valid = '0;
    checks++; if (out_valid !== 2'b11) begin failures++; $display("FAIL rmid_pre got=%b exp=11", out_valid); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (out_valid !== 2'b00 || out_data !== '0 || out_col !== '0 || slot_almost_full !== '0) begin failures++; $display("FAIL rmid_clear got=v%b d%h c%h af%h exp=all0", out_valid, out_data, out_col, slot_almost_full); end
    out_ready = 2'b11;
    tick;
    tick;
    checks++; if (out_valid !== 2'b00) begin failures++; $display("FAIL rmid_stale got=%b exp=00", out_valid); end
    in_valid[0] = 4'b1001; in_data[0][0] = 32'hF0; in_data[0][3] = 32'hF3;
    tick;
    in_valid = '0;
    tick;
    checks++; if (out_col[0] !== 2'd0 || out_data[0] !== 32'hF0) begin failures++; $display("FAIL rmid_ptr0 got=c%0d d%h exp=c0 df0", out_col[0], out_data[0]); end
    tick;
    checks++; if (out_col[0] !== 2'd3 || out_data[0] !== 32'hF3) begin failures++; $display("FAIL rmid_ptr3 got=c%0d d%h exp=c3 df3", out_col[0], out_data[0]); end
    in_valid[0][1] = 1'b1; in_data[0][1] = 32'h5A;
    tick;
    in_valid = '0;
    tick;
    checks++; if (out_valid !== 2'b01 || out_col[0] !== 2'd1 || out_data[0] !== 32'h5A) begin failures++; $display("FAIL rmid_new got=v%b c%0d d%h exp=v01 c1 d5a", out_valid, out_col[0], out_data[0]); end
  endtask

  task automatic test_hold;
    do_reset;
    cfg_rr_en = 1'b1; out_ready = 2'b00;
    in_valid[0] = 4'b0110; in_data[0][1] = 32'hBEEF; in_data[0][2] = 32'hCAFE;
    tick;
    in_valid = '0;
    tick;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid[0] !== 1'b1 || out_data[0] !== 32'hBEEF || out_col[0] !== 2'd1) begin failures++; $display("FAIL hold_%0d got=v%b d%h c%0d exp=v1 dbeef c1", k, out_valid[0], out_data[0], out_col[0]); end
      tick;
    end
    out_ready[0] = 1'b1;
    tick;
    checks++; if (out_data[0] !== 32'hCAFE || out_col[0] !== 2'd2) begin failures++; $display("FAIL hold_release got=d%h c%0d exp=dcafe c2", out_data[0], out_col[0]); end
  endtask

  initial begin
    rst = 1'b1; cfg_rr_en = 1'b1; in_valid = '0; in_data = '0;
    ovf_clear = 1'b0; out_ready = 2'b11;
    test_reset;
    test_single;
    test_round_robin;
    test_fixed_priority;
    test_overflow;
    test_full_push_pop;
    test_reset_mid;
    test_hold;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
